pipeline_fetch: RTL and testbench
=================================

Name: pipeline_fetch

Overview:
Instruction-fetch stage directly upstream of the five-stage decode/readreg/execute/memwrt/regwrt assembly; produces the IR and PC consumed by decode.
Drives a synchronous-read instruction memory with 1-cycle read latency. Holds its output across stage-1 stalls using an internal hold buffer. Accepts branch redirects from later stages and stops fetching on HALT.

Parameters:
PC_W, 8, PC and instruction-memory address width
IR_W, 16, instruction width
RESET_PC, 8'h00, first fetch address after reset
BUBBLE_IR, 16'h0000, IR driven when output is invalid (downstream decodes as no-op)
HALT_IR, 16'hE000, encoding that halts fetch

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
update_in  input  1  stage 1 accepts current IR this cycle (0 = stall)
redirect_in  input  1  branch/jump taken; squash and refetch
redirect_pc_in  input  PC_W  redirect target address
imem_addr  output  PC_W  instruction memory read address (combinational from pc_q)
imem_rdata  input  IR_W  memory data, valid 1 cycle after the address was presented
IR_out  output  IR_W  instruction to decode
PC_out  output  PC_W  address of IR_out plus 1, mod 2^PC_W
valid_out  output  1  IR_out is a real instruction
halted_out  output  1  fetch stopped on HALT
fetch_count_out  output  16  accepted-instruction counter, saturating

Behaviour:
- Registers:
  - pc_q: next fetch address
  - cur_pc_q: address whose data is on imem_rdata or in the hold buffer
  - cur_valid_q
  - hold_valid_q, hold_ir_q
  - halted_q
  - cnt_q
- Reset (async, rst_n=0):
  - pc_q=RESET_PC, cur_pc_q=RESET_PC
  - cur_valid_q=0, hold_valid_q=0, hold_ir_q=0, halted_q=0, cnt_q=0
  - Resulting outputs: valid_out=0, IR_out=BUBBLE_IR, PC_out=RESET_PC+1, halted_out=0, fetch_count_out=0, imem_addr=RESET_PC.
- Combinational:
  - imem_addr=pc_q
  - valid_out=cur_valid_q
  - IR_out = !cur_valid_q ? BUBBLE_IR : hold_valid_q ? hold_ir_q : imem_rdata
  - PC_out=cur_pc_q+1 (wraps)
- Priority, evaluated each edge: redirect > stall > advance.
- Redirect (redirect_in=1, regardless of update_in):
  - pc_q<=redirect_pc_in, cur_pc_q<=redirect_pc_in
  - cur_valid_q<=0, hold_valid_q<=0, halted_q<=0
  - Next cycle is a bubble; target instruction is valid the cycle after.
- Stall (update_in=0, no redirect):
  - pc_q, cur_pc_q, cur_valid_q held.
  - If hold_valid_q=0: hold_ir_q<=imem_rdata, hold_valid_q<=1.
  - IR_out stays stable for the whole stall.
- Advance (update_in=1, no redirect):
  - cur_pc_q<=pc_q, hold_valid_q<=0.
  - If halted_q=0 and next halted=0: pc_q<=pc_q+1 (wrap 2^PC_W-1 -> 0), cur_valid_q<=1.
  - Otherwise pc_q held, cur_valid_q<=0.
- Halt:
  - When valid_out=1, update_in=1, redirect_in=0 and IR_out==HALT_IR: halted_q<=1, and that same edge already suppresses the pc_q increment.
  - The HALT instruction itself is delivered downstream.
  - Afterwards valid_out=0 until redirect or reset.
- Effective states:
  - FILL: cur_valid=0, not halted; after reset or redirect, lasts 1 cycle.
  - RUN: valid, hold empty.
  - STALL: hold_valid=1 from the 2nd stall cycle on.
  - HALT: halted_q=1.
- Counter: cnt_q increments when valid_out and update_in and !redirect_in; saturates at 16'hFFFF.
- Reset mid-stall or mid-redirect: everything returns to reset values immediately (asynchronous).

Decomposition:
- Shared package fetch_pkg holds the PC_W/IR_W defaults, the RESET_PC, BUBBLE_IR and HALT_IR constants, and the state enum {FILL, RUN, STALL, HALT} for waveform debug.
- One sub-module is natural: fetch_hold_buf, containing the hold_valid/hold_ir skid register and the IR_out mux.

Test Plan:
- Reset, mem[k]=16'h1000+k, update_in=1 -> cycle 1 valid_out=0, IR_out=0000; then IR_out 1000, 1001, 1002 with PC_out 01, 02, 03 on consecutive cycles.
- update_in=0 for 3 cycles while IR_out=1004 -> IR_out=1004, PC_out=05 held throughout; after release, next cycle IR_out=1005, no skip or duplicate; fetch_count increments once per accepted instruction.
- redirect_in=1, redirect_pc_in=8'h40 during a stall -> next cycle valid_out=0; following cycle IR_out=mem[40], PC_out=41; the hold buffer is not reused.
- mem[06]=E000 -> E000 delivered with valid_out=1; after it is accepted, halted_out=1, valid_out=0, imem_addr frozen; redirect to 8'h10 -> halted_out=0, IR_out=mem[10] two cycles later.
- Start at pc=8'hFE -> PC_out sequence FF, 00, 01; imem_addr wraps FF -> 00.
- rst_n asserted mid-stall with hold_valid=1 -> all outputs at reset values before the next edge; fetch_count_out=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared widths, constants and debug state encoding for the instruction-fetch stage.
package fetch_pkg;

   localparam int              FETCH_PC_W      = 8;
   localparam int              FETCH_IR_W      = 16;
   localparam logic [7:0]      FETCH_RESET_PC  = 8'h00;
   localparam logic [15:0]     FETCH_BUBBLE_IR = 16'h0000;
   localparam logic [15:0]     FETCH_HALT_IR   = 16'hE000;

   // Effective stage state, derived from the datapath registers for waveform debug.
   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      HALT  = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Skid register that freezes the memory read data while decode stalls, plus the IR output mux.
module fetch_hold_buf
   import fetch_pkg::*;
#(
   parameter int              IR_W      = FETCH_IR_W,
   parameter logic [IR_W-1:0] BUBBLE_IR = FETCH_BUBBLE_IR
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            capture_i,
   input  logic            cur_valid_i,
   input  logic [IR_W-1:0] rdata_i,
   output logic [IR_W-1:0] ir_o,
   output logic            hold_valid_o
);

   logic            hold_valid_q, hold_valid_d;
   logic [IR_W-1:0] hold_ir_q, hold_ir_d;

   // Only the first stall cycle captures: afterwards rdata already shows the next address.
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_ir_d    = hold_ir_q;
      if (clear_i) begin
         hold_valid_d = 1'b0;
      end else if (capture_i && !hold_valid_q) begin
         hold_valid_d = 1'b1;
         hold_ir_d    = rdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hold_valid_q <= 1'b0;
         hold_ir_q    <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_ir_q    <= hold_ir_d;
      end
   end

   assign ir_o         = !cur_valid_i ? BUBBLE_IR : (hold_valid_q ? hold_ir_q : rdata_i);
   assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction-fetch stage: drives a 1-cycle-latency instruction memory, holds IR across
// decode stalls, takes branch redirects and stops fetching after delivering HALT.
module pipeline_fetch
   import fetch_pkg::*;
#(
   parameter int              PC_W      = FETCH_PC_W,
   parameter int              IR_W      = FETCH_IR_W,
   parameter logic [PC_W-1:0] RESET_PC  = FETCH_RESET_PC,
   parameter logic [IR_W-1:0] BUBBLE_IR = FETCH_BUBBLE_IR,
   parameter logic [IR_W-1:0] HALT_IR   = FETCH_HALT_IR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            update_in,
   input  logic            redirect_in,
   input  logic [PC_W-1:0] redirect_pc_in,
   output logic [PC_W-1:0] imem_addr,
   input  logic [IR_W-1:0] imem_rdata,
   output logic [IR_W-1:0] IR_out,
   output logic [PC_W-1:0] PC_out,
   output logic            valid_out,
   output logic            halted_out,
   output logic [15:0]     fetch_count_out,
   output logic [1:0]      state_out
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] cur_pc_q, cur_pc_d;
   logic            cur_valid_q, cur_valid_d;
   logic            halted_q, halted_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            hold_valid;
   logic            accept;
   logic            halt_now;
   fetch_state_e    state_dbg;

   // Handshake: IR_out/PC_out transfer to decode on any edge where valid_out and update_in
   // are both high and redirect_in is low; a redirect squashes whatever is on the output.
   assign accept   = cur_valid_q && update_in && !redirect_in;
   assign halt_now = accept && (IR_out == HALT_IR);

   fetch_hold_buf #(
      .IR_W      (IR_W),
      .BUBBLE_IR (BUBBLE_IR)
   ) u_hold_buf (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .clear_i      (redirect_in || update_in),
      .capture_i    (!redirect_in && !update_in),
      .cur_valid_i  (cur_valid_q),
      .rdata_i      (imem_rdata),
      .ir_o         (IR_out),
      .hold_valid_o (hold_valid)
   );

   always_comb begin
      pc_d        = pc_q;
      cur_pc_d    = cur_pc_q;
      cur_valid_d = cur_valid_q;
      halted_d    = halted_q;
      if (redirect_in) begin
         pc_d        = redirect_pc_in;
         cur_pc_d    = redirect_pc_in;
         cur_valid_d = 1'b0;
         halted_d    = 1'b0;
      end else if (update_in) begin
         cur_pc_d = pc_q;
         halted_d = halted_q || halt_now;
         // The HALT edge itself already stops the increment so imem_addr freezes at once.
         if (!halted_q && !halt_now) begin
            pc_d        = pc_q + PC_W'(1);
            cur_valid_d = 1'b1;
         end else begin
            cur_valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (accept && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         cur_pc_q    <= RESET_PC;
         cur_valid_q <= 1'b0;
         halted_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         pc_q        <= pc_d;
         cur_pc_q    <= cur_pc_d;
         cur_valid_q <= cur_valid_d;
         halted_q    <= halted_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_dbg = RUN;
      if (halted_q) begin
         state_dbg = HALT;
      end else if (!cur_valid_q) begin
         state_dbg = FILL;
      end else if (hold_valid) begin
         state_dbg = STALL;
      end
   end

   assign imem_addr       = pc_q;
   assign valid_out       = cur_valid_q;
   assign PC_out          = cur_pc_q + PC_W'(1);
   assign halted_out      = halted_q;
   assign fetch_count_out = cnt_q;
   assign state_out       = state_dbg;

endmodule

// File: tb/tb_pipeline_fetch.sv
// Bench for pipeline_fetch: behavioural 1-cycle instruction memory, scoreboard of expected
// {IR, PC} pairs for every accepted instruction, and per-scenario directed checks.
module tb_pipeline_fetch;

   logic        clk;
   logic        rst_n;
   logic        update_in;
   logic        redirect_in;
   logic [7:0]  redirect_pc_in;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [15:0] IR_out;
   logic [7:0]  PC_out;
   logic        valid_out;
   logic        halted_out;
   logic [15:0] fetch_count_out;
   logic [1:0]  state_out;

   logic [15:0] mem [256];
   logic [23:0] exp_q [$];
   logic [15:0] exp_cnt;
   int          checks;
   int          errors;

   pipeline_fetch dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .update_in       (update_in),
      .redirect_in     (redirect_in),
      .redirect_pc_in  (redirect_pc_in),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .IR_out          (IR_out),
      .PC_out          (PC_out),
      .valid_out       (valid_out),
      .halted_out      (halted_out),
      .fetch_count_out (fetch_count_out),
      .state_out       (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= mem[imem_addr];

   // One clock: drive inputs at negedge, retire an accepted instruction against the queue.
   task automatic cycle(input logic upd, input logic red, input logic [7:0] rpc);
      logic [23:0] e;
      @(negedge clk);
      update_in      = upd;
      redirect_in    = red;
      redirect_pc_in = rpc;
      if (valid_out && upd && !red) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got IR %h PC %h expected nothing", IR_out, PC_out);
         end else begin
            e = exp_q.pop_front();
            if ({IR_out, PC_out} !== e) begin
               errors++;
               $display("FAIL sb_data got IR %h PC %h expected IR %h PC %h",
                        IR_out, PC_out, e[23:8], e[7:0]);
            end
            if (exp_cnt != 16'hFFFF) exp_cnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] a);
      logic [7:0] n;
      n = a + 8'd1;
      exp_q.push_back({mem[a], n});
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got %0d pending expected 0", name, exp_q.size());
      end
      checks++;
      if (fetch_count_out !== exp_cnt) begin
         errors++;
         $display("FAIL %s_count got %h expected %h", name, fetch_count_out, exp_cnt);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if ({valid_out, IR_out, PC_out, halted_out, fetch_count_out, imem_addr, state_out} !==
          {1'b0, 16'h0000, 8'h01, 1'b0, 16'h0000, 8'h00, 2'd0}) begin
         errors++;
         $display("FAIL %s got v=%b ir=%h pc=%h h=%b cnt=%h addr=%h st=%0d expected v=0 ir=0000 pc=01 h=0 cnt=0000 addr=00 st=0",
                  name, valid_out, IR_out, PC_out, halted_out, fetch_count_out, imem_addr, state_out);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      update_in = 1'b0;
      redirect_in = 1'b0;
      redirect_pc_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_sequence();
      checks++;
      if (valid_out !== 1'b0 || IR_out !== 16'h0000) begin
         errors++;
         $display("FAIL fill got v=%b ir=%h expected v=0 ir=0000", valid_out, IR_out);
      end
      for (int k = 0; k < 3; k++) push_exp(8'(k));
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (valid_out !== 1'b1 || IR_out !== 16'h1000 || PC_out !== 8'h01 || state_out !== 2'd1) begin
         errors++;
         $display("FAIL first_ir got v=%b ir=%h pc=%h st=%0d expected v=1 ir=1000 pc=01 st=1",
                  valid_out, IR_out, PC_out, state_out);
      end
      repeat (3) cycle(1'b1, 1'b0, 8'h00);
      check_drained("sequence");
   endtask

   task automatic test_stall();
      push_exp(8'h03);
      cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 8'h00);
         checks++;
         if (IR_out !== 16'h1004 || PC_out !== 8'h05 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold_%0d got v=%b ir=%h pc=%h expected v=1 ir=1004 pc=05",
                     i, valid_out, IR_out, PC_out);
         end
      end
      checks++;
      if (state_out !== 2'd2) begin
         errors++;
         $display("FAIL stall_state got %0d expected 2", state_out);
      end
      push_exp(8'h04);
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (IR_out !== 16'h1005 || PC_out !== 8'h06) begin
         errors++;
         $display("FAIL stall_release got ir=%h pc=%h expected ir=1005 pc=06", IR_out, PC_out);
      end
      check_drained("stall");
   endtask

   task automatic test_redirect();
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h40);
      checks++;
      if (valid_out !== 1'b0 || imem_addr !== 8'h40) begin
         errors++;
         $display("FAIL redirect_bubble got v=%b addr=%h expected v=0 addr=40", valid_out, imem_addr);
      end
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (valid_out !== 1'b1 || IR_out !== 16'h1040 || PC_out !== 8'h41) begin
         errors++;
         $display("FAIL redirect_target got v=%b ir=%h pc=%h expected v=1 ir=1040 pc=41",
                  valid_out, IR_out, PC_out);
      end
      push_exp(8'h40);
      cycle(1'b1, 1'b0, 8'h00);
      check_drained("redirect");
   endtask

   task automatic test_halt();
      mem[8'h06] = 16'hE000;
      cycle(1'b0, 1'b1, 8'h04);
      cycle(1'b1, 1'b0, 8'h00);
      push_exp(8'h04);
      push_exp(8'h05);
      push_exp(8'h06);
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (valid_out !== 1'b1 || IR_out !== 16'hE000 || PC_out !== 8'h07) begin
         errors++;
         $display("FAIL halt_deliver got v=%b ir=%h pc=%h expected v=1 ir=E000 pc=07",
                  valid_out, IR_out, PC_out);
      end
      cycle(1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (halted_out !== 1'b1 || valid_out !== 1'b0 || imem_addr !== 8'h07 || state_out !== 2'd3) begin
            errors++;
            $display("FAIL halt_frozen_%0d got h=%b v=%b addr=%h st=%0d expected h=1 v=0 addr=07 st=3",
                     i, halted_out, valid_out, imem_addr, state_out);
         end
         cycle(1'b1, 1'b0, 8'h00);
      end
      cycle(1'b1, 1'b1, 8'h10);
      checks++;
      if (halted_out !== 1'b0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL halt_exit got h=%b v=%b expected h=0 v=0", halted_out, valid_out);
      end
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (valid_out !== 1'b1 || IR_out !== 16'h1010 || PC_out !== 8'h11) begin
         errors++;
         $display("FAIL halt_refetch got v=%b ir=%h pc=%h expected v=1 ir=1010 pc=11",
                  valid_out, IR_out, PC_out);
      end
      push_exp(8'h10);
      cycle(1'b1, 1'b0, 8'h00);
      mem[8'h06] = 16'h1006;
      check_drained("halt");
   endtask

   task automatic test_wrap();
      cycle(1'b0, 1'b1, 8'hFE);
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (imem_addr !== 8'hFF || IR_out !== 16'h10FE || PC_out !== 8'hFF) begin
         errors++;
         $display("FAIL wrap_first got addr=%h ir=%h pc=%h expected addr=FF ir=10FE pc=FF",
                  imem_addr, IR_out, PC_out);
      end
      push_exp(8'hFE);
      push_exp(8'hFF);
      push_exp(8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      checks++;
      if (imem_addr !== 8'h00 || PC_out !== 8'h00 || IR_out !== 16'h10FF) begin
         errors++;
         $display("FAIL wrap_addr got addr=%h ir=%h pc=%h expected addr=00 ir=10FF pc=00",
                  imem_addr, IR_out, PC_out);
      end
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      check_drained("wrap");
   endtask

   task automatic test_reset_mid_stall();
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      checks++;
      if (state_out !== 2'd2 || IR_out !== 16'h1001) begin
         errors++;
         $display("FAIL pre_reset_stall got st=%0d ir=%h expected st=2 ir=1001", state_out, IR_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_stall");
      exp_cnt = 16'h0000;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 8'h00);
      push_exp(8'h00);
      cycle(1'b1, 1'b0, 8'h00);
      check_drained("restart");
   endtask

   task automatic test_saturate();
      logic [7:0] a;
      logic       upd;
      int         accepted;
      a = 8'h01;
      accepted = 0;
      while (accepted < 65536) begin
         upd = ($urandom_range(0, 7) != 0);
         if (upd) begin
            push_exp(a);
            a = a + 8'd1;
            accepted++;
         end
         cycle(upd, 1'b0, 8'h00);
      end
      checks++;
      if (fetch_count_out !== 16'hFFFF) begin
         errors++;
         $display("FAIL saturate got %h expected FFFF", fetch_count_out);
      end
      check_drained("saturate");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      exp_cnt = 16'h0000;
      for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
      test_reset();
      test_sequence();
      test_stall();
      test_redirect();
      test_halt();
      test_wrap();
      test_reset_mid_stall();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
